// File: rtl/irq_aggregator.sv
// irq_aggregator: edge-captured sticky pending/overflow flags OR-reduced to irq; define IRQ_AGG_SYNC_EN to add a 2-flop input synchronizer
module irq_aggregator #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  input  logic [N-1:0] mask,
  input  logic [N-1:0] clr,
  output logic [N-1:0] pending,
  output logic [N-1:0] ovf,
  output logic         irq,
  output logic         irq_rise
);
  logic [N-1:0] w_in, w_rise, w_pend_n, w_ovf_n;
  logic [N-1:0] r_s, r_h, r_pend, r_ovf;
  logic         r_irq_d;
`ifdef IRQ_AGG_SYNC_EN
  logic [N-1:0] r_sy1, r_sy2;
  // two-flop synchronizer for request lines asynchronous to clk
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sy1 <= '0;
      r_sy2 <= '0;
    end else begin
      r_sy1 <= req_in;
      r_sy2 <= r_sy1;
    end
  assign w_in = r_sy2;
`else
  assign w_in = req_in;
`endif
  // sample and history registers; h resets to 0 so a line high at release counts once
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_s <= '0;
      r_h <= '0;
    end else begin
      r_s <= w_in;
      r_h <= r_s;
    end
  // set wins over clear; overflow marks a new event landing on an unacknowledged one
  always_comb begin
    w_rise   = r_s & ~r_h;
    w_pend_n = w_rise | (r_pend & ~clr);
    w_ovf_n  = ~clr & (r_ovf | (w_rise & r_pend));
  end
  // sticky flags and previous irq level for rise detection
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pend  <= '0;
      r_ovf   <= '0;
      r_irq_d <= 1'b0;
    end else begin
      r_pend  <= w_pend_n;
      r_ovf   <= w_ovf_n;
      r_irq_d <= irq;
    end
  assign pending  = r_pend;
  assign ovf      = r_ovf;
  assign irq      = |(r_pend & mask);
  assign irq_rise = irq & ~r_irq_d;
endmodule

// File: tb/tb_irq_aggregator.sv
// tb_irq_aggregator: directed scenarios plus randomized traffic against a history-based reference model
module tb_irq_aggregator;
`ifdef IRQ_AGG_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in = '0, mask = '0, clr = '0;
  logic [7:0] pending, ovf;
  logic       irq, irq_rise;
  int         passed = 0, total = 0;
  logic [7:0] hist [0:4095];
  int         ec;
  logic [7:0] m_pend, m_ovf;
  logic       m_irqd;

  irq_aggregator #(.N(8)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .mask(mask), .clr(clr),
    .pending(pending), .ovf(ovf), .irq(irq), .irq_rise(irq_rise)
  );

  always #5 clk = ~clk;

  // value of req_in sampled at edge j since reset release (0 before release)
  function automatic logic [7:0] h_at(input int j);
    return (j < 0) ? 8'h00 : hist[j];
  endfunction

  // per-line pending/overflow rules applied to one edge
  function automatic logic [15:0] model_next(input logic [7:0] rv, input logic [7:0] c,
                                             input logic [7:0] p, input logic [7:0] o);
    logic [7:0] np, no;
    np = p;
    no = o;
    for (int i = 0; i < 8; i++)
      if (rv[i] && !c[i]) begin
        np[i] = 1'b1;
        no[i] = o[i] | p[i];
      end else if (c[i]) begin
        np[i] = rv[i];
        no[i] = 1'b0;
      end
    return {no, np};
  endfunction

  // an event on line i is a 0->1 step in the sampled input history, seen 1+LAT edges late
  always @(posedge clk or posedge rst)
    if (rst) begin
      ec     <= 0;
      m_pend <= '0;
      m_ovf  <= '0;
      m_irqd <= 1'b0;
    end else begin
      {m_ovf, m_pend} <= model_next(h_at(ec - 1 - LAT) & ~h_at(ec - 2 - LAT), clr, m_pend, m_ovf);
      m_irqd <= |(m_pend & mask);
      if (ec < 4096) begin
        hist[ec] <= req_in;
        ec <= ec + 1;
      end
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int l);
    req_in[l] = 1'b1;
    tick;
    req_in[l] = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mask = 8'hFF;
    req_in = '0;
    clr = '0;
    tick;
    tick;
    total++;
    if ({pending, ovf, irq, irq_rise} !== 18'h0)
      $display("FAIL reset_during got %h/%h/%b/%b want 0", pending, ovf, irq, irq_rise);
    else passed++;
    rst = 1'b0;
    tick;
    tick;
    total++;
    if ({pending, ovf, irq, irq_rise} !== 18'h0)
      $display("FAIL reset_after got %h/%h/%b/%b want 0", pending, ovf, irq, irq_rise);
    else passed++;
  endtask

  task automatic test_pulse;
    int n;
    mask = 8'h08;
    req_in[3] = 1'b1;
    tick;
    req_in[3] = 1'b0;
    n = 1;
    while (!pending[3] && n < 10) begin
      tick;
      n++;
    end
    total++;
    if (n !== 2 + LAT) $display("FAIL pulse_latency got %0d want %0d", n, 2 + LAT);
    else passed++;
    total++;
    if ({pending, irq, irq_rise} !== {8'h08, 2'b11})
      $display("FAIL pulse_capture got %h/%b/%b want 08/1/1", pending, irq, irq_rise);
    else passed++;
    tick;
    total++;
    if ({irq, irq_rise} !== 2'b10) $display("FAIL pulse_rise_once got %b/%b want 1/0", irq, irq_rise);
    else passed++;
    clr = 8'h08;
    tick;
    clr = '0;
    total++;
    if ({pending, irq} !== 9'h0) $display("FAIL pulse_clear got %h/%b want 00/0", pending, irq);
    else passed++;
  endtask

  task automatic test_ovf;
    pulse(3);
    pulse(3);
    repeat (4) tick;
    total++;
    if ({ovf, pending} !== 16'h0808) $display("FAIL ovf_set got ovf %h pend %h want 08/08", ovf, pending);
    else passed++;
    clr = 8'h08;
    tick;
    clr = '0;
    total++;
    if ({ovf, pending} !== 16'h0) $display("FAIL ovf_clear got ovf %h pend %h want 00/00", ovf, pending);
    else passed++;
  endtask

  task automatic test_set_wins;
    pulse(5);
    pulse(5);
    repeat (4) tick;
    total++;
    if ({ovf, pending} !== 16'h2020) $display("FAIL setwin_pre got ovf %h pend %h want 20/20", ovf, pending);
    else passed++;
    req_in[5] = 1'b1;
    tick;
    req_in[5] = 1'b0;
    repeat (LAT) tick;
    clr = 8'h20;
    tick;
    clr = '0;
    total++;
    if ({ovf, pending} !== 16'h0020) $display("FAIL setwin got ovf %h pend %h want 00/20", ovf, pending);
    else passed++;
    clr = 8'h20;
    tick;
    clr = '0;
  endtask

  task automatic test_mask;
    mask = '0;
    pulse(0);
    repeat (4) tick;
    total++;
    if ({pending, irq} !== {8'h01, 1'b0}) $display("FAIL mask_off got %h/%b want 01/0", pending, irq);
    else passed++;
    mask = 8'h01;
    #1;
    total++;
    if ({irq, irq_rise} !== 2'b11) $display("FAIL unmask got %b/%b want 1/1", irq, irq_rise);
    else passed++;
    tick;
    total++;
    if ({irq, irq_rise} !== 2'b10) $display("FAIL unmask_once got %b/%b want 1/0", irq, irq_rise);
    else passed++;
    clr = 8'h01;
    tick;
    clr = '0;
  endtask

  task automatic test_reset_mid;
    mask = 8'hFF;
    pulse(6);
    repeat (4) tick;
    total++;
    if (pending !== 8'h40) $display("FAIL rmid_pre got %h want 40", pending);
    else passed++;
    req_in[2] = 1'b1;
    tick;
    req_in[2] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({pending, ovf, irq, irq_rise} !== 18'h0)
      $display("FAIL rmid_async got %h/%h/%b/%b want 0", pending, ovf, irq, irq_rise);
    else passed++;
    #1;
    rst = 1'b0;
    repeat (6) tick;
    total++;
    if ({pending, ovf} !== 16'h0) $display("FAIL rmid_discard got %h/%h want 00/00", pending, ovf);
    else passed++;
    req_in[1] = 1'b1;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    repeat (6) tick;
    total++;
    if ({pending, ovf} !== 16'h0200) $display("FAIL rmid_held got %h/%h want 02/00", pending, ovf);
    else passed++;
    req_in[1] = 1'b0;
    clr = 8'h02;
    tick;
    clr = '0;
  endtask

  task automatic test_random;
    logic [7:0] e_irqv;
    for (int c = 0; c < 400; c++) begin
      req_in = 8'($urandom) & 8'($urandom);
      clr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
      tick;
      e_irqv = m_pend & mask;
      total++;
      if ({pending, ovf} !== {m_pend, m_ovf})
        $display("FAIL rand_flags cyc %0d got %h/%h want %h/%h", c, pending, ovf, m_pend, m_ovf);
      else passed++;
      total++;
      if ({irq, irq_rise} !== {|e_irqv, (|e_irqv) & ~m_irqd})
        $display("FAIL rand_irq cyc %0d got %b/%b want %b/%b", c, irq, irq_rise, |e_irqv, (|e_irqv) & ~m_irqd);
      else passed++;
    end
    req_in = '0;
    clr = '0;
  endtask

  initial begin
    test_reset;
    test_pulse;
    test_ovf;
    test_set_wins;
    test_mask;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/irq_aggregator.md
# irq_aggregator

Collects N asynchronous request lines into sticky, individually clearable pending flags and reduces the masked flags to a single interrupt line. It is the stage directly upstream of the OR-reduction output. It supplies the registered, edge-captured terms that are ORed together, and it adds the capture, acknowledge and overflow bookkeeping that a bare OR gate lacks. Typical placement is between peripheral event sources and a CPU interrupt input.

## Interface
- `N`, default 8: number of request lines, 1..32.
- `clk`  in  1: single clock; every register is clocked on its rising edge.
- `rst`  in  1: asynchronous, active-high reset. Assertion immediately forces all registers to 0; release is synchronous to `clk`.
- `req_in`  in  N: request lines; an event is a 0→1 transition.
- `mask`  in  N: 1 = line enabled onto `irq`. Capture is not affected by `mask`.
- `clr`  in  N: write-1-to-clear pulse per line, sampled each `clk` edge.
- `pending`  out  N: sticky event flags (registered).
- `ovf`  out  N: sticky overflow flags (registered).
- `irq`  out  1: `|(pending & mask)`, purely combinational from registers and `mask`.
- `irq_rise`  out  1: single-cycle pulse in the first cycle `irq` is 1 after being 0.

## Operation
- Input path per line: optional two-flop synchronizer, then sample register `s`, then history register `h`. Define `rise[i] = s[i] & ~h[i]`.
- Pending update per bit, evaluated at each edge:
  - `rise` = 1, `clr` = 0: `pending` ← 1. If `pending` was already 1, `ovf` ← 1.
  - `rise` = 0, `clr` = 1: `pending` ← 0, `ovf` ← 0.
  - `rise` = 1, `clr` = 1: set wins. `pending` stays or becomes 1, and `ovf` ← 0 because the old event is acknowledged and the new one is held.
  - `rise` = 0, `clr` = 0: hold.
- Each bit is independent; clearing bit i never affects bit j.
- `irq_rise`: register `irq_d` ← `irq` each edge; `irq_rise = irq & ~irq_d`.
- Changing `mask` alone can raise `irq` and therefore `irq_rise`. This is intended: unmasking a pending line raises an interrupt.
- Reset value of every register, including the synchronizer flops, `s`, `h`, `pending`, `ovf` and `irq_d`, is 0. Outputs after reset are `pending` = 0, `ovf` = 0, `irq` = 0 and `irq_rise` = 0.
- A line held high through reset release is captured as one event, because `h` resets to 0.
- Asserting reset mid-operation discards all pending, overflow and in-flight synchronizer state.

## Timing
Edge numbering: `req_in` goes high before edge k.
- Without synchronizer:
  - `s` = 1 at k.
  - `rise` is high during cycle k..k+1.
  - `pending` = 1 after edge k+1, and `irq` follows in the same cycle if masked in.
  - `irq_rise` is high for cycle k+1..k+2 only.
- With synchronizer: every one of the above moves two edges later, so `pending` = 1 after edge k+3.
- A `clr` sampled at edge m makes `pending` = 0 after edge m, and `irq` drops in the same cycle.
- Minimum detectable pulse:
  - High: one `clk` period, sampled at one edge.
  - Low: one sampled low between highs to register a second event.
- Throughput: one event per line per two cycles.

## Configuration
- `IRQ_AGG_SYNC_EN` defined: a two-flop synchronizer is inserted ahead of `s` on every line, adding 2 cycles of latency. Required when `req_in` is asynchronous to `clk`.
- Not defined: `req_in` is assumed synchronous to `clk` and goes straight into `s`, giving the latency above with no extra stages.

## Test plan
- Reset with N = 8, `mask` = 8'hFF, `req_in` = 0: outputs `pending` = 0, `ovf` = 0, `irq` = 0 and `irq_rise` = 0, both during and after reset.
- Pulse `req_in[3]` high for 1 cycle, no sync, `mask` = 8'h08: `pending` = 8'h08 after edge k+1, `irq` = 1 and `irq_rise` = 1 for exactly one cycle. Then pulse `clr` = 8'h08 and check `pending` = 0 and `irq` = 0.
- Pulse `req_in[3]` twice with no clear: after the second pulse `ovf` = 8'h08 while `pending` = 8'h08. Then `clr` = 8'h08 returns both to 0.
- Drive `clr[5]` and a `rise` on line 5 in the same cycle with `pending[5]` = 1 and `ovf[5]` = 1: result is `pending[5]` = 1 and `ovf[5]` = 0.
- `mask` = 0 with an event on line 0: `pending` = 8'h01 and `irq` = 0. Then set `mask` = 8'h01: `irq` = 1 and `irq_rise` pulses once.
- With `IRQ_AGG_SYNC_EN` defined, repeat the line-3 pulse case: `pending` must rise exactly 2 edges later than in the unsynchronized build. Also assert `rst` mid-synchronizer: no event appears after release unless `req_in` is still high.
